// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen and consumed by the renderers.
// The generator uses the master modport. Consumers use the slave modport.
interface vga_timing_gen_if #(
    parameter int FC_W = 16
);
    logic            hs;
    logic            vs;
    logic            blank;
    logic [9:0]      DrawX;
    logic [9:0]      DrawY;
    logic            line_start;
    logic            frame_start;
    logic [FC_W-1:0] frame_count;

    modport master (
        output hs, vs, blank, DrawX, DrawY, line_start, frame_start, frame_count
    );

    modport slave (
        input  hs, vs, blank, DrawX, DrawY, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator. Every output is a flop that is loaded from the
// next-state counter values, so sync, blank and the pulses are aligned with DrawX/DrawY.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int FC_W      = 16
) (
    input  logic              vga_clk,
    input  logic              reset,
    vga_timing_gen_if.master  vif
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // The coordinate counters are 10 bits wide, so neither total can exceed 1024.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
        end
    endgenerate

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;

    always_comb begin
        // NOTE: every signal written here gets a default value first. Without it, a
        // missed branch leaves the value unassigned and synthesis infers a latch.
        y_nxt  = vif.DrawY;
        h_wrap = (vif.DrawX == H_LAST);
        v_wrap = h_wrap && (vif.DrawY == V_LAST);
        x_nxt  = h_wrap ? '0 : vif.DrawX + 10'd1;
        if (v_wrap) begin
            y_nxt = '0;
        end else if (h_wrap) begin
            y_nxt = vif.DrawY + 10'd1;
        end
    end

    // The (0,0) state reached through reset is not a wrap, so both pulses clear here.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            vif.DrawX       <= '0;
            vif.DrawY       <= '0;
            vif.hs          <= 1'b1;
            vif.vs          <= 1'b1;
            vif.blank       <= 1'b1;
            vif.line_start  <= 1'b0;
            vif.frame_start <= 1'b0;
            vif.frame_count <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments, so every flop samples the
            // values from before this edge, no matter how the statements are ordered.
            vif.DrawX       <= x_nxt;
            vif.DrawY       <= y_nxt;
            vif.hs          <= !((x_nxt >= HS_START) && (x_nxt <= HS_END));
            vif.vs          <= !((y_nxt >= VS_START) && (y_nxt <= VS_END));
            vif.blank       <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
            vif.line_start  <= h_wrap;
            vif.frame_start <= v_wrap;
            if (v_wrap) begin
                vif.frame_count <= vif.frame_count + FC_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Checks a full-size instance and a shrunken FC_W=2 instance in lockstep against an
// arithmetic model driven by the pixel count since the last reset release.
module tb_vga_timing_gen;
    logic vga_clk = 1'b0;
    logic reset   = 1'b1;

    always #20 vga_clk = ~vga_clk;

    vga_timing_gen_if #(.FC_W(16)) vif_a ();
    vga_timing_gen_if #(.FC_W(2))  vif_b ();

    vga_timing_gen dut_a (
        .vga_clk (vga_clk),
        .reset   (reset),
        .vif     (vif_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_VISIBLE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .FC_W(2)
    ) dut_b (
        .vga_clk (vga_clk),
        .reset   (reset),
        .vif     (vif_b)
    );

    typedef struct {
        int x, y, fc;
        bit hs, vs, blank, ls, fs;
    } exp_t;

    int total = 0;
    int bad   = 0;
    int n     = 0;   // pixels clocked since reset release
    int cyc   = 0;
    int last_ls_a = -1, last_ls_b = -1, last_fs_b = -1;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (n=%0d)", tag, got, exp, n);
        end
    endtask

    function automatic exp_t model(input int cnt, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb, input int fcw);
        exp_t e;
        int ht = hv + hf + hsw + hb;
        int vt = vv + vf + vsw + vb;
        e.x     = cnt % ht;
        e.y     = (cnt / ht) % vt;
        e.hs    = !(e.x >= hv + hf && e.x < hv + hf + hsw);
        e.vs    = !(e.y >= vv + vf && e.y < vv + vf + vsw);
        e.blank = (e.x < hv) && (e.y < vv);
        e.ls    = (cnt > 0) && (e.x == 0);
        e.fs    = (cnt > 0) && (e.x == 0) && (e.y == 0);
        e.fc    = (cnt / (ht * vt)) % (1 << fcw);
        return e;
    endfunction

    task automatic check_all();
        exp_t ea = model(n, 640, 16, 96, 48, 480, 10, 2, 33, 16);
        exp_t eb = model(n, 16, 4, 6, 4, 10, 2, 2, 3, 2);
        check("a.x",  vif_a.DrawX,       ea.x);
        check("a.y",  vif_a.DrawY,       ea.y);
        check("a.hs", vif_a.hs,          ea.hs);
        check("a.vs", vif_a.vs,          ea.vs);
        check("a.bl", vif_a.blank,       ea.blank);
        check("a.ls", vif_a.line_start,  ea.ls);
        check("a.fs", vif_a.frame_start, ea.fs);
        check("a.fc", vif_a.frame_count, ea.fc);
        check("b.x",  vif_b.DrawX,       eb.x);
        check("b.y",  vif_b.DrawY,       eb.y);
        check("b.hs", vif_b.hs,          eb.hs);
        check("b.vs", vif_b.vs,          eb.vs);
        check("b.bl", vif_b.blank,       eb.blank);
        check("b.ls", vif_b.line_start,  eb.ls);
        check("b.fs", vif_b.frame_start, eb.fs);
        check("b.fc", vif_b.frame_count, eb.fc);
    endtask

    task automatic check_periods();
        if (vif_a.line_start) begin
            if (last_ls_a >= 0) check("a.line_period", cyc - last_ls_a, 800);
            last_ls_a = cyc;
        end
        if (vif_b.line_start) begin
            if (last_ls_b >= 0) check("b.line_period", cyc - last_ls_b, 30);
            last_ls_b = cyc;
        end
        if (vif_b.frame_start) begin
            if (last_fs_b >= 0) check("b.frame_period", cyc - last_fs_b, 510);
            last_fs_b = cyc;
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        if (!reset) n++;
        cyc++;
        @(negedge vga_clk);
        check_all();
        check_periods();
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, then holds it for some edges.
    task automatic pulse_reset(input int hold);
        #2 reset = 1'b1;
        #1;
        n = 0;
        last_ls_a = -1;
        last_ls_b = -1;
        last_fs_b = -1;
        check_all();
        repeat (hold) step();
        #2 reset = 1'b0;
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        check_all();
        #2 reset = 1'b0;

        // Two lines of the full-size raster, then enough for five small frames.
        repeat (1600) step();
        repeat (1100) step();
        check("b.five_frames_fc", vif_b.frame_count, ((n / 510) % 4));

        // Reset while the small instance sits inside both sync pulses.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step();
            if (!vif_b.hs && !vif_b.vs) found = 1'b1;
        end
        check("b.found_both_syncs", found, 1);
        pulse_reset(3);

        // Randomized reset assertions over a long run.
        for (int i = 0; i < 12000; i++) begin
            step();
            if ($urandom_range(0, 2999) == 0) pulse_reset($urandom_range(1, 4));
        end
        repeat (1200) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates raster timing for the 640x480@60 Hz display path from the 25 MHz pixel clock.
It produces hs/vs sync, the visible-region flag blank, and the current pixel coordinates DrawX/DrawY. The background renderer and the sprite renderers consume these and produce colour one cycle later.
It also provides per-line and per-frame pulses plus a frame counter, used for animation and for frame-synchronous register updates.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
FC_W, 16, frame_count width

Ports:
vga_clk  in  1  pixel clock, 25 MHz; all state on posedge
reset  in  1  asynchronous, active-high; clears all state
hs  out  1  horizontal sync, active-low
vs  out  1  vertical sync, active-low
blank  out  1  1 = current pixel is visible (display enable), 0 = porch/sync
DrawX  out  10  current horizontal count, 0..H_TOTAL-1
DrawY  out  10  current vertical count, 0..V_TOTAL-1
line_start  out  1  one-cycle pulse on the first pixel of each line
frame_start  out  1  one-cycle pulse on the first pixel of each frame
frame_count  out  FC_W  completed-frame counter

Behaviour:
- Derived constants: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525). Both must be <= 1024; the elaboration-time check fails otherwise.
- Counter update:
  - DrawX increments by 1 every cycle; at H_TOTAL-1 it wraps to 0.
  - DrawY increments only on the cycle where DrawX wraps; at V_TOTAL-1 with DrawX wrapping, both go to 0.
- All outputs are registers. hs/vs/blank/pulses are computed from the next-state counter values, so every output describes the same pixel as DrawX/DrawY in the same cycle, with zero skew.
- hs = 0 iff DrawX in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] ([656,751]); else 1.
- vs = 0 iff DrawY in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] ([490,491]); else 1. vs changes only on a line boundary, coincident with DrawX=0.
- blank = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
- Wrap pulses:
  - line_start = 1 for exactly the cycle in which DrawX = 0, entered via wrap from H_TOTAL-1.
  - frame_start = 1 for exactly the cycle in which (DrawX,DrawY) = (0,0), entered via wrap from (H_TOTAL-1,V_TOTAL-1). line_start is also 1 in that cycle.
  - frame_count increments by 1 on the same clock edge that raises frame_start. It wraps from 2^FC_W-1 to 0 silently.
- Reset (async assert, any time, including mid-line or mid-sync):
  - DrawX=0, DrawY=0, hs=1, vs=1, blank=1, line_start=0, frame_start=0, frame_count=0.
  - The state (0,0) reached by reset is NOT a frame_start or line_start. The first pulses occur at the first natural wrap after release.
- Reset deassertion: counting resumes on the first posedge with reset low. The first cycle after release shows DrawX=1.
- Sync outputs never glitch: they are driven directly from flops, with no combinational decode on the outputs.
- Frame period: exactly H_TOTAL*V_TOTAL = 420000 cycles between consecutive frame_start pulses. Line period: exactly H_TOTAL = 800 cycles between consecutive line_start pulses.

Test Plan:
- Reset then run 1600 cycles -> DrawX sequence 0,1..799,0,1..; DrawY=0 for DrawX 0..799 of the first line, then 1. line_start is high only at cycle 800. frame_start stays 0.
- Check the horizontal window on line 0 -> hs=0 exactly for DrawX 656..751 (96 cycles). blank=1 for DrawX 0..639 and 0 for 640..799.
- Run 2 full frames -> vs=0 exactly on lines 490-491 (1600 cycles). blank=0 on all of lines 480..524. frame_start pulses are exactly 420000 cycles apart. frame_count reads 1 then 2.
- Assert reset at DrawX=700, DrawY=491 (during both syncs) -> outputs go immediately (async) to hs=1, vs=1, blank=1, DrawX=0, DrawY=0, frame_count=0. No frame_start after release until 420000 cycles have elapsed.
- Override FC_W=2 and run 5 frames -> frame_count sequence 1,2,3,0,1.
- Last pixel (799,524) -> next cycle shows (0,0) with frame_start=1 and line_start=1 together, hs=1, vs=1, blank=1.
